// File: rtl/avalon_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-MM pipelined slave.
// Commands are serialized through an IDLE/BUSY handshake. A small in-order tag
// FIFO remembers which master issued each accepted read, so every readdatavalid
// beat is steered back to its issuer.
module avalon_arbiter #(
    parameter int unsigned NBDATABYTES = 2,
    parameter int unsigned NBADDRBITS  = 8,
    parameter int unsigned MAXPENDING  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // master 0
    input  logic [NBADDRBITS-1:0]    m0_address,
    input  logic [NBDATABYTES-1:0]   m0_byteenable,
    input  logic                     m0_read,
    input  logic                     m0_write,
    input  logic [8*NBDATABYTES-1:0] m0_writedata,
    output logic                     m0_waitrequest,
    output logic [8*NBDATABYTES-1:0] m0_readdata,
    output logic                     m0_readdatavalid,
    // master 1
    input  logic [NBADDRBITS-1:0]    m1_address,
    input  logic [NBDATABYTES-1:0]   m1_byteenable,
    input  logic                     m1_read,
    input  logic                     m1_write,
    input  logic [8*NBDATABYTES-1:0] m1_writedata,
    output logic                     m1_waitrequest,
    output logic [8*NBDATABYTES-1:0] m1_readdata,
    output logic                     m1_readdatavalid,
    // shared slave
    output logic [NBADDRBITS-1:0]    s_address,
    output logic [NBDATABYTES-1:0]   s_byteenable,
    output logic                     s_read,
    output logic                     s_write,
    output logic [8*NBDATABYTES-1:0] s_writedata,
    input  logic                     s_waitrequest,
    input  logic [8*NBDATABYTES-1:0] s_readdata,
    input  logic                     s_readdatavalid,
    output logic                     protocol_err
);

    localparam int unsigned DW   = 8 * NBDATABYTES;
    localparam int unsigned PTRW = (MAXPENDING > 1) ? $clog2(MAXPENDING) : 1;
    localparam int unsigned CNTW = $clog2(MAXPENDING + 1);
    localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAXPENDING);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(MAXPENDING - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                r_state, w_state_next;
    logic                  r_grant, w_grant_next;
    logic                  r_rr_ptr, w_rr_next;
    logic [MAXPENDING-1:0] r_tags;
    logic [PTRW-1:0]       r_rd_ptr, r_wr_ptr;
    logic [CNTW-1:0]       r_count;
    logic                  r_err;

    logic                  w_busy, w_not_full, w_empty;
    logic                  w_elig0, w_elig1;
    logic                  w_g_read, w_g_write;
    logic [NBADDRBITS-1:0] w_g_address;
    logic [NBDATABYTES-1:0] w_g_byteenable;
    logic [DW-1:0]         w_g_writedata;
    logic                  w_s_read, w_s_write;
    logic                  w_accept, w_push, w_pop, w_head;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_busy     = (r_state == StBusy);
    assign w_empty    = (r_count == '0);
    // Eligibility looks only at the registered count: a same-cycle pop does not free a slot.
    assign w_not_full = (r_count != MAX_CNT);
    assign w_elig0    = m0_write | (m0_read & w_not_full);
    assign w_elig1    = m1_write | (m1_read & w_not_full);

    assign w_g_read       = r_grant ? m1_read       : m0_read;
    assign w_g_write      = r_grant ? m1_write      : m0_write;
    assign w_g_address    = r_grant ? m1_address    : m0_address;
    assign w_g_byteenable = r_grant ? m1_byteenable : m0_byteenable;
    assign w_g_writedata  = r_grant ? m1_writedata  : m0_writedata;

    // Read+write together is forwarded as a write only.
    assign w_s_read  = w_busy & w_g_read & ~w_g_write;
    assign w_s_write = w_busy & w_g_write;
    assign w_accept  = (w_s_read | w_s_write) & ~s_waitrequest;
    assign w_push    = w_accept & w_s_read;
    assign w_pop     = s_readdatavalid & ~w_empty;
    assign w_head    = r_tags[r_rd_ptr];

    // Arbitration and command-phase next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        unique case (r_state)
            StIdle: begin
                if (w_elig0 && w_elig1) begin
                    w_grant_next = r_rr_ptr;
                end else if (w_elig0) begin
                    w_grant_next = 1'b0;
                end else if (w_elig1) begin
                    w_grant_next = 1'b1;
                end
                if (w_elig0 || w_elig1) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (w_accept) begin
                    w_state_next = StIdle;
                    w_rr_next    = ~r_grant;
                end else if (!w_g_read && !w_g_write) begin
                    // Granted master withdrew: release without issuing anything.
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_grant  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_next;
        end
    end

    // In-order tag FIFO of outstanding read owners.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tags   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= r_grant;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky protocol error: read+write together, or return beat with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_busy && w_g_read && w_g_write) || (s_readdatavalid && w_empty)) begin
            r_err <= 1'b1;
        end
    end

    // Slave command mux, master stalls and combinational read return.
    always_comb begin
        s_address        = '0;
        s_byteenable     = '0;
        s_writedata      = '0;
        s_read           = w_s_read;
        s_write          = w_s_write;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = w_pop & ~w_head;
        m1_readdatavalid = w_pop & w_head;
        protocol_err     = r_err;
        if (w_busy) begin
            s_address    = w_g_address;
            s_byteenable = w_g_byteenable;
            s_writedata  = w_g_writedata;
            if (r_grant) begin
                m1_waitrequest = s_waitrequest;
            end else begin
                m0_waitrequest = s_waitrequest;
            end
        end
    end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_avalon_arbiter;

    localparam int NB = 2;
    localparam int AB = 8;
    localparam int MP = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AB-1:0] m_addr [2];
    logic [NB-1:0] m_be   [2];
    logic [DW-1:0] m_wd   [2];
    logic [1:0]    m_rd, m_wr;
    logic          s_wait, s_rdv;
    logic [DW-1:0] s_rdata;

    logic [1:0]    d_wait, d_rdv;
    logic [DW-1:0] d_rdata0, d_rdata1, d_s_wd;
    logic [AB-1:0] d_s_addr;
    logic [NB-1:0] d_s_be;
    logic          d_s_rd, d_s_wr, d_err;

    avalon_arbiter #(.NBDATABYTES(NB), .NBADDRBITS(AB), .MAXPENDING(MP)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m_addr[0]), .m0_byteenable(m_be[0]), .m0_read(m_rd[0]),
        .m0_write(m_wr[0]), .m0_writedata(m_wd[0]), .m0_waitrequest(d_wait[0]),
        .m0_readdata(d_rdata0), .m0_readdatavalid(d_rdv[0]),
        .m1_address(m_addr[1]), .m1_byteenable(m_be[1]), .m1_read(m_rd[1]),
        .m1_write(m_wr[1]), .m1_writedata(m_wd[1]), .m1_waitrequest(d_wait[1]),
        .m1_readdata(d_rdata1), .m1_readdatavalid(d_rdv[1]),
        .s_address(d_s_addr), .s_byteenable(d_s_be), .s_read(d_s_rd), .s_write(d_s_wr),
        .s_writedata(d_s_wd), .s_waitrequest(s_wait), .s_readdata(s_rdata),
        .s_readdatavalid(s_rdv), .protocol_err(d_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level model: phase, granted master, preferred master, owner queue.
    bit mb_busy;
    int mb_g, mb_rr;
    int tq[$];
    bit mb_err;

    // Observations for directed checks.
    int n_swr, n_srd;
    int n_wlow [2];
    int n_rdv  [2];
    logic [AB-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [AB-1:0] rd_addr_log[$];
    logic [DW-1:0] rdv_log0[$], rdv_log1[$];

    // Agents.
    typedef struct {int due; logic [DW-1:0] data;} ret_t;
    ret_t rq[$];
    bit auto_m, ret_en, rand_wait, fixed_lat;
    logic [DW-1:0] dcount;
    bit [1:0] acc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_swr = 0; n_srd = 0;
        n_wlow[0] = 0; n_wlow[1] = 0; n_rdv[0] = 0; n_rdv[1] = 0;
        wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        rdv_log0.delete(); rdv_log1.delete();
    endtask

    // One clock cycle: compare at negedge, advance model, then drive agents after posedge.
    task automatic step();
        logic [AB-1:0] ea;
        logic [NB-1:0] ebe;
        logic [DW-1:0] ewd;
        logic          erd, ewr;
        logic [1:0]    ewait, erdv;
        int            sz;
        bit            el0, el1;
        @(negedge clk);
        ea = '0; ebe = '0; ewd = '0; erd = 1'b0; ewr = 1'b0;
        if (mb_busy) begin
            ea  = m_addr[mb_g];
            ebe = m_be[mb_g];
            ewd = m_wd[mb_g];
            ewr = m_wr[mb_g];
            erd = m_rd[mb_g] & ~m_wr[mb_g];
        end
        sz = tq.size();
        for (int n = 0; n < 2; n++) begin
            ewait[n] = (mb_busy && mb_g == n) ? s_wait : 1'b1;
            erdv[n]  = s_rdv && sz > 0 && tq[0] == n;
        end
        chk("s_address", d_s_addr, ea);
        chk("s_byteenable", d_s_be, ebe);
        chk("s_writedata", d_s_wd, ewd);
        chk("s_read", d_s_rd, erd);
        chk("s_write", d_s_wr, ewr);
        chk("waitrequest", d_wait, ewait);
        chk("readdatavalid", d_rdv, erdv);
        chk("m0_readdata", d_rdata0, s_rdata);
        chk("m1_readdata", d_rdata1, s_rdata);
        chk("protocol_err", d_err, mb_err);

        acc_m[0] = (m_rd[0] | m_wr[0]) & ~d_wait[0];
        acc_m[1] = (m_rd[1] | m_wr[1]) & ~d_wait[1];
        if (!rst) begin
            n_swr += int'(d_s_wr);
            n_srd += int'(d_s_rd);
            if (d_s_wr && !s_wait) begin
                wr_addr_log.push_back(d_s_addr);
                wr_data_log.push_back(d_s_wd);
            end
            if (d_s_rd) rd_addr_log.push_back(d_s_addr);
            for (int n = 0; n < 2; n++) begin
                n_wlow[n] += int'(!d_wait[n]);
                n_rdv[n]  += int'(d_rdv[n]);
            end
            if (d_rdv[0]) rdv_log0.push_back(d_rdata0);
            if (d_rdv[1]) rdv_log1.push_back(d_rdata1);
            if (ret_en && d_s_rd && !s_wait) begin
                ret_t r;
                r.due = cyc + (fixed_lat ? 3 : int'($urandom_range(1, 5)));
                if (fixed_lat) begin
                    dcount = dcount + 16'd1;
                    r.data = dcount;
                end else begin
                    r.data = DW'($urandom);
                end
                rq.push_back(r);
            end
        end

        if (rst) begin
            mb_busy = 0; mb_g = 0; mb_rr = 0; mb_err = 0;
            tq.delete();
        end else begin
            if (mb_busy && m_rd[mb_g] && m_wr[mb_g]) mb_err = 1;
            if (s_rdv && sz == 0) mb_err = 1;
            el0 = m_wr[0] || (m_rd[0] && sz < MP);
            el1 = m_wr[1] || (m_rd[1] && sz < MP);
            if (s_rdv && sz > 0) void'(tq.pop_front());
            if (!mb_busy) begin
                if (el0 && el1) mb_g = mb_rr;
                else if (el0) mb_g = 0;
                else if (el1) mb_g = 1;
                mb_busy = el0 || el1;
            end else if ((erd || ewr) && !s_wait) begin
                if (erd) tq.push_back(mb_g);
                mb_rr   = 1 - mb_g;
                mb_busy = 0;
            end else if (!m_rd[mb_g] && !m_wr[mb_g]) begin
                mb_busy = 0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rst) rq.delete();
        if (ret_en) begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                s_rdv   = 1'b1;
                s_rdata = rq[0].data;
                void'(rq.pop_front());
            end else begin
                s_rdv   = 1'b0;
                s_rdata = DW'($urandom);
            end
        end
        if (rand_wait) s_wait = ($urandom_range(0, 9) < 3);
        if (auto_m) begin
            for (int n = 0; n < 2; n++) begin
                if (acc_m[n] || ((m_rd[n] || m_wr[n]) && $urandom_range(0, 49) == 0)) begin
                    m_rd[n] = 1'b0;
                    m_wr[n] = 1'b0;
                end
                if (!m_rd[n] && !m_wr[n] && $urandom_range(0, 9) < 4) begin
                    m_addr[n] = AB'($urandom);
                    m_be[n]   = NB'($urandom);
                    m_wd[n]   = DW'($urandom);
                    if ($urandom_range(0, 1) == 1) m_wr[n] = 1'b1;
                    else m_rd[n] = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_rd = '0; m_wr = '0; s_rdv = 1'b0; s_wait = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_stats();
    endtask

    // Hold a request until the master sees it accepted, then drop it.
    task automatic issue(input int n, input bit wr, input bit rd,
                         input logic [AB-1:0] a, input logic [DW-1:0] d);
        int k;
        m_addr[n] = a; m_wd[n] = d; m_be[n] = '1;
        m_wr[n] = wr; m_rd[n] = rd;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc_m[n] && k < 20);
        chk("issue_accepted", acc_m[n], 1);
        m_rd[n] = 1'b0;
        m_wr[n] = 1'b0;
    endtask

    initial begin
        int k;
        auto_m = 0; ret_en = 0; rand_wait = 0; fixed_lat = 0; dcount = '0;
        s_rdata = '0;
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = '0; m_be[n] = '0; m_wd[n] = '0;
        end
        mb_busy = 0; mb_g = 0; mb_rr = 0; mb_err = 0;
        do_reset();

        // Reset values.
        chk("rst_s_write", d_s_wr, 0);
        chk("rst_s_read", d_s_rd, 0);
        chk("rst_s_address", d_s_addr, 0);
        chk("rst_waitrequest", d_wait, 2'b11);
        chk("rst_rdv", d_rdv, 2'b00);
        chk("rst_err", d_err, 0);

        // Single m0 write.
        issue(0, 1, 0, 8'h10, 16'hBEEF);
        step();
        chk("single_wr_cycles", n_swr, 1);
        chk("single_wr_log", wr_addr_log.size(), 1);
        if (wr_addr_log.size() > 0) begin
            chk("single_wr_addr", wr_addr_log[0], 8'h10);
            chk("single_wr_data", wr_data_log[0], 16'hBEEF);
        end
        chk("single_m0_wlow", n_wlow[0], 1);
        chk("single_m1_wlow", n_wlow[1], 0);

        // Contention: both masters write continuously.
        do_reset();
        m_addr[0] = 8'h20; m_wd[0] = 16'h0A0A; m_be[0] = '1;
        m_addr[1] = 8'h30; m_wd[1] = 16'h0B0B; m_be[1] = '1;
        m_wr = 2'b11;
        repeat (8) step();
        m_wr = 2'b00;
        chk("cont_count", wr_addr_log.size(), 4);
        if (wr_addr_log.size() == 4) begin
            chk("cont_0", wr_addr_log[0], 8'h20);
            chk("cont_1", wr_addr_log[1], 8'h30);
            chk("cont_2", wr_addr_log[2], 8'h20);
            chk("cont_3", wr_addr_log[3], 8'h30);
        end
        chk("cont_m0_rate", n_wlow[0], 2);
        chk("cont_m1_rate", n_wlow[1], 2);

        // Pipelined reads with fixed latency 3.
        do_reset();
        ret_en = 1; fixed_lat = 1; dcount = 16'hD000;
        issue(0, 0, 1, 8'hA0, '0);
        issue(1, 0, 1, 8'hB0, '0);
        issue(0, 0, 1, 8'hC0, '0);
        repeat (8) step();
        chk("pipe_m0_count", rdv_log0.size(), 2);
        chk("pipe_m1_count", rdv_log1.size(), 1);
        if (rdv_log0.size() == 2 && rdv_log1.size() == 1) begin
            chk("pipe_m0_d1", rdv_log0[0], 16'hD001);
            chk("pipe_m1_d2", rdv_log1[0], 16'hD002);
            chk("pipe_m0_d3", rdv_log0[1], 16'hD003);
        end
        ret_en = 0; fixed_lat = 0; s_rdv = 1'b0;

        // Full FIFO blocks m0 reads while m1 writes proceed.
        do_reset();
        for (int i = 0; i < MP; i++) issue(0, 0, 1, AB'(8'h40 + i), '0);
        clear_stats();
        m_addr[0] = 8'h45; m_rd[0] = 1'b1;
        m_addr[1] = 8'h31; m_wd[1] = 16'h5555; m_wr[1] = 1'b1;
        repeat (8) step();
        m_wr[1] = 1'b0;
        chk("full_m0_blocked", n_wlow[0], 0);
        chk("full_m1_writes", n_swr, 4);
        s_rdv = 1'b1; s_rdata = 16'h1234;
        step();
        s_rdv = 1'b0;
        chk("full_pop_rdv", n_rdv[0], 1);
        if (rdv_log0.size() > 0) chk("full_pop_data", rdv_log0[0], 16'h1234);
        k = 0;
        do begin
            step();
            k++;
        end while (!acc_m[0] && k < 6);
        chk("full_fifth_read", acc_m[0], 1);
        m_rd[0] = 1'b0;

        // Wait stall during an m1 read.
        do_reset();
        s_wait = 1'b1;
        m_addr[1] = 8'h55; m_rd[1] = 1'b1;
        repeat (4) step();
        s_wait = 1'b0;
        step();
        m_rd[1] = 1'b0;
        step();
        chk("stall_read_cycles", n_srd, 4);
        k = 0;
        foreach (rd_addr_log[i]) if (rd_addr_log[i] == 8'h55) k++;
        chk("stall_addr_stable", k, 4);
        s_rdv = 1'b1; s_rdata = 16'h7777;
        step();
        s_rdv = 1'b0;
        step();
        chk("stall_m1_rdv", n_rdv[1], 1);
        chk("stall_m0_rdv", n_rdv[0], 0);
        chk("stall_no_err", d_err, 0);

        // Read+write together forwards a write and flags an error.
        do_reset();
        issue(0, 1, 1, 8'h66, 16'hA5A5);
        step();
        chk("rw_write", n_swr, 1);
        chk("rw_no_read", n_srd, 0);
        chk("rw_err", d_err, 1);

        // Return beat with nothing outstanding.
        do_reset();
        s_rdv = 1'b1; s_rdata = 16'h0077;
        step();
        s_rdv = 1'b0;
        repeat (3) step();
        chk("empty_rdv_none", n_rdv[0] + n_rdv[1], 0);
        chk("empty_rdv_err", d_err, 1);

        // Reset while BUSY and stalled.
        m_addr[0] = 8'h12; m_wd[0] = 16'h3456; m_wr[0] = 1'b1; s_wait = 1'b1;
        step();
        step();
        chk("busy_before_rst", d_s_wr, 1);
        rst = 1'b1;
        step();
        chk("rst_busy_s_write", d_s_wr, 0);
        chk("rst_busy_s_address", d_s_addr, 0);
        chk("rst_busy_wait", d_wait, 2'b11);
        chk("rst_busy_err", d_err, 0);
        rst = 1'b0;
        m_wr[0] = 1'b0; s_wait = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        auto_m = 1; ret_en = 1; rand_wait = 1;
        repeat (3000) step();
        auto_m = 0; rand_wait = 0;
        m_rd = '0; m_wr = '0; s_wait = 1'b0;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
